// File: rtl/lcd_seq_driver.sv
// lcd_seq_driver: walks the LCD data ROM and writes each word to an
// HD44780-compatible controller over the 8-bit parallel bus. It uses
// timed delays only; the busy flag is never read.
//
// Ports:
//   CLK      - single clock, rising edge
//   RESET    - asynchronous active-high reset
//   START    - one-cycle pulse; restarts the sequence from address 0 (DONE only)
//   romaddr  - ROM address (7 bits)
//   romq     - ROM data, combinational w.r.t. romaddr (bit 8 = RS, 7:0 = DB)
//   LCD_E    - enable strobe
//   LCD_RS   - register select (0 = command, 1 = data)
//   LCD_RW   - read/write, tied to 0
//   LCD_DB   - data bus
//   BUSY     - high while the sequence runs
//   DONE     - high once the sequence has finished
module lcd_seq_driver #(
  parameter int unsigned T_PWRON = 750000,
  parameter int unsigned T_AS    = 2,
  parameter int unsigned T_PW    = 12,
  parameter int unsigned T_H     = 2,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  output logic [6:0] romaddr,
  input  logic [8:0] romq,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DB,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [2:0] {
    S_PWRON,
    S_FETCH,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT,
    S_DONE
  } state_t;

  // Terminal counts: each phase lasts T cycles, counter runs 0..T-1.
  localparam logic [CNT_W-1:0] PWRON_LAST = CNT_W'(T_PWRON - 1);
  localparam logic [CNT_W-1:0] AS_LAST    = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] PW_LAST    = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(T_CLR - 1);

  localparam logic [8:0] WORD_TERM = 9'h0FF;
  localparam logic [6:0] ADDR_LAST = 7'd127;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [8:0]       word;
  logic [CNT_W-1:0] wait_last;

  // Clear display / return home need the long execution time.
  always_comb begin
    wait_last = CMD_LAST;
    if (word == 9'h001 || word == 9'h002 || word == 9'h003) begin
      wait_last = CLR_LAST;
    end
  end

  // Write-only interface.
  assign LCD_RW = 1'b0;

  // Sequencer with registered bus outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_PWRON;
      cnt     <= '0;
      word    <= '0;
      romaddr <= '0;
      LCD_E   <= 1'b0;
      LCD_RS  <= 1'b0;
      LCD_DB  <= '0;
      BUSY    <= 1'b1;
      DONE    <= 1'b0;
    end else begin
      case (state)
        S_PWRON: begin
          if (cnt == PWRON_LAST) begin
            cnt   <= '0;
            state <= S_FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FETCH: begin
          word <= romq;
          if (romq == WORD_TERM) begin
            // Terminator: no bus write, RS/DB keep their last values.
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            LCD_RS <= romq[8];
            LCD_DB <= romq[7:0];
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == AS_LAST) begin
            cnt   <= '0;
            LCD_E <= 1'b1;
            state <= S_PULSE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt == PW_LAST) begin
            cnt   <= '0;
            LCD_E <= 1'b0;
            state <= S_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == H_LAST) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == wait_last) begin
            cnt <= '0;
            if (romaddr == ADDR_LAST) begin
              // End of ROM: stop without wrapping the address.
              state <= S_DONE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end else begin
              romaddr <= romaddr + 7'd1;
              state   <= S_FETCH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          LCD_E <= 1'b0;
          if (START) begin
            romaddr <= '0;
            DONE    <= 1'b0;
            BUSY    <= 1'b1;
            state   <= S_FETCH;
          end
        end
        default: begin
          state <= S_PWRON;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_seq_driver.sv
// Directed bench for lcd_seq_driver: a ROM model feeds the DUT, expected
// bus words are queued when a sequence is launched and popped on each
// rising edge of LCD_E; bus timing is checked on every sampled cycle.
module tb_lcd_seq_driver;

  localparam int unsigned P_PWRON = 10;
  localparam int unsigned P_AS    = 2;
  localparam int unsigned P_PW    = 4;
  localparam int unsigned P_H     = 2;
  localparam int unsigned P_CMD   = 8;
  localparam int unsigned P_CLR   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] romaddr;
  logic [8:0] romq;
  logic       lcd_e, lcd_rs, lcd_rw, busy, done;
  logic [7:0] lcd_db;
  logic       rom_mode = 1'b0;

  lcd_seq_driver #(
    .T_PWRON(P_PWRON), .T_AS(P_AS), .T_PW(P_PW), .T_H(P_H),
    .T_CMD(P_CMD), .T_CLR(P_CLR), .CNT_W(20)
  ) dut (
    .CLK(clk), .RESET(rst), .START(start), .romaddr(romaddr), .romq(romq),
    .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_DB(lcd_db),
    .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  // ROM model: short program, or 9'h120 everywhere.
  always_comb begin
    if (rom_mode) begin
      romq = 9'h120;
    end else begin
      case (romaddr)
        7'd0:    romq = 9'h038;
        7'd1:    romq = 9'h00F;
        7'd2:    romq = 9'h001;
        7'd3:    romq = 9'h150;
        default: romq = 9'h0FF;
      endcase
    end
  end

  int         checks = 0;
  int         errors = 0;
  logic [8:0] sb[$];

  // Monitor state
  int         e = -1;
  int         pulses = 0;
  int         hi_cnt = 0;
  int         hold_left = 0;
  int         last_fall = 0;
  int         last_rise = 0;
  int         gap3 = -1;
  logic       gap_armed = 1'b0;
  logic       prev_e = 1'b0;
  logic [6:0] prev_addr = '0;
  logic [8:0] hist1 = '0, hist2 = '0, rise_bus = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_seq();
    sb.push_back(9'h038);
    sb.push_back(9'h00F);
    sb.push_back(9'h001);
    sb.push_back(9'h150);
  endtask

  task automatic clear_monitor();
    prev_e = 1'b0; hold_left = 0; hi_cnt = 0;
    hist1 = '0; hist2 = '0; rise_bus = '0; prev_addr = '0;
  endtask

  // One clock: sample 1 time unit after the rising edge and run bus checks.
  task automatic tick();
    logic [8:0] cur;
    logic [8:0] exp;
    @(posedge clk);
    #1;
    e++;
    cur = {lcd_rs, lcd_db};
    if (lcd_e && !prev_e) begin
      pulses++;
      last_rise = e;
      check("setup_stable", 32'({hist2, hist1}), 32'({cur, cur}));
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check("bus_word", 32'(cur), 32'(exp));
      end
      rise_bus = cur;
      hi_cnt = 1;
    end else if (lcd_e) begin
      hi_cnt++;
      check("pulse_stable", 32'(cur), 32'(rise_bus));
    end else if (prev_e) begin
      check("pulse_width", 32'(hi_cnt), 32'(P_PW));
      check("hold_stable", 32'(cur), 32'(rise_bus));
      last_fall = e;
      hold_left = int'(P_H) - 1;
    end else if (hold_left > 0) begin
      check("hold_stable", 32'(cur), 32'(rise_bus));
      hold_left--;
    end
    if (romaddr != prev_addr && gap_armed && pulses == 3 && gap3 < 0) begin
      gap3 = e - last_fall;
    end
    check("rw_zero", 32'(lcd_rw), 32'd0);
    hist2 = hist1;
    hist1 = cur;
    prev_e = lcd_e;
    prev_addr = romaddr;
  endtask

  // Power-on window: outputs stay at reset values for the first T_PWRON edges.
  task automatic check_poweron();
    for (int i = 0; i < int'(P_PWRON); i++) begin
      tick();
      check("pwron_outs", 32'({romaddr, lcd_e, lcd_rs, lcd_db, busy, done}),
            32'({7'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0}));
    end
  endtask

  // Tick until DONE rises, with a bounded budget; optional mid-run START.
  task automatic wait_done(input int budget, input int start_at, output int done_e);
    for (int i = 0; i < budget && !done; i++) begin
      start = (e == start_at) ? 1'b1 : 1'b0;
      tick();
      if (start_at >= 0 && e == start_at + 1) begin
        check("mid_start_addr", 32'(romaddr), 32'd1);
      end
    end
    start = 1'b0;
    check("done_timeout", 32'(done), 32'd1);
    done_e = e;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    tick();
    start = 1'b0;
    s = e;
  endtask

  initial begin
    int done_e;
    int s;

    // Reset and power-on
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'({romaddr, lcd_e, lcd_rs, lcd_rw, lcd_db, busy, done}),
          32'({7'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0}));
    rst = 1'b0;
    e = -1;
    push_seq();
    gap_armed = 1'b1;
    check_poweron();

    // Short program, with an ignored START during a wait phase
    wait_done(400, 40, done_e);
    gap_armed = 1'b0;
    check("done_cycle", 32'(done_e), 32'd90);
    check("done_addr", 32'(romaddr), 32'd4);
    check("pulse_count", 32'(pulses), 32'd4);
    check("clear_gap", 32'(gap3), 32'(P_H + P_CLR));
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    repeat (30) tick();
    check("no_fifth", 32'({pulses, 7'(romaddr), done, lcd_e}), 32'({4, 7'd4, 1'b1, 1'b0}));

    // Restart from DONE: no power-on wait
    pulses = 0;
    push_seq();
    pulse_start(s);
    check("restart_state", 32'({romaddr, busy, done}), 32'({7'd0, 1'b1, 1'b0}));
    for (int i = 0; i < 10 && !lcd_e; i++) tick();
    check("restart_rise", 32'(last_rise - s), 32'd3);
    wait_done(400, -1, done_e);
    check("restart_done", 32'(done_e - s), 32'd81);
    check("restart_pulses", 32'(pulses), 32'd4);

    // Reset during an E pulse
    pulses = 0;
    push_seq();
    pulse_start(s);
    for (int i = 0; i < 10 && !lcd_e; i++) tick();
    tick();
    check("pre_reset_e", 32'(lcd_e), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", 32'({romaddr, lcd_e, lcd_rs, lcd_db, busy, done}),
          32'({7'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0}));
    sb.delete();
    clear_monitor();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    e = -1;
    pulses = 0;
    push_seq();
    check_poweron();
    wait_done(400, -1, done_e);
    check("rerun_done", 32'(done_e), 32'd90);
    check("rerun_pulses", 32'(pulses), 32'd4);

    // Full ROM of data writes: stop at address 127
    rom_mode = 1'b1;
    pulses = 0;
    for (int i = 0; i < 128; i++) sb.push_back(9'h120);
    pulse_start(s);
    wait_done(3000, -1, done_e);
    check("full_pulses", 32'(pulses), 32'd128);
    check("full_addr", 32'(romaddr), 32'd127);
    check("full_sb", 32'(sb.size()), 32'd0);
    check("full_done_cycle", 32'(done_e - s), 32'(128 * 17));
    repeat (30) tick();
    check("no_wrap", 32'({pulses, 7'(romaddr), done}), 32'({128, 7'd127, 1'b1}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_seq_driver.md
# lcd_seq_driver

Sequencer that walks the LCD data ROM and drives an HD44780-compatible character LCD through its 8-bit parallel bus. It sits directly downstream of the 9-bit LCD data ROM: it presents `romaddr`, reads back `romq` (bit 8 = RS, bits 7:0 = command/character), and generates RS/E/DB with the controller's setup, pulse-width, hold and execution delays. Sequence: power-on wait, then one LCD write per ROM word until the terminator word.

## Interface
- `T_PWRON`, 750000: power-on wait cycles after reset (15 ms @ 50 MHz)
- `T_AS`, 2: RS/DB setup cycles before E rises
- `T_PW`, 12: E high cycles
- `T_H`, 2: RS/DB hold cycles after E falls
- `T_CMD`, 2000: execution wait cycles for normal writes (40 us)
- `T_CLR`, 82000: execution wait cycles for clear/home (1.64 ms)
- `CNT_W`, 20: delay counter width; must hold max(all T_*)
- `CLK` in 1: single clock, rising edge
- `RESET` in 1: asynchronous, active-high reset
- `START` in 1: one-cycle pulse; restarts the sequence from address 0
- `romaddr` out 7: ROM address
- `romq` in 9: ROM data, combinational w.r.t. `romaddr`
- `LCD_E` out 1: LCD enable strobe
- `LCD_RS` out 1: register select (0 = command, 1 = data)
- `LCD_RW` out 1: read/write; constant 0 (write only)
- `LCD_DB` out 8: LCD data bus
- `BUSY` out 1: high while the sequence runs
- `DONE` out 1: high once the sequence has finished

## Operation
- Reset values: `romaddr`=0, `LCD_E`=0, `LCD_RS`=0, `LCD_RW`=0, `LCD_DB`=0, `BUSY`=1, `DONE`=0, state PWRON, counter 0.
- States: PWRON, FETCH, SETUP, PULSE, HOLD, WAIT, DONE.
- PWRON: count `T_PWRON` cycles, then FETCH.
- FETCH (1 cycle): register `romq` into `word`. If `word`==9'h0FF, go to DONE (terminator; no bus write). Otherwise go to SETUP.
- SETUP (`T_AS` cycles): `LCD_RS`=`word[8]`, `LCD_DB`=`word[7:0]`, `LCD_E`=0.
- PULSE (`T_PW` cycles): `LCD_E`=1. RS/DB unchanged.
- HOLD (`T_H` cycles): `LCD_E`=0. RS/DB unchanged.
- WAIT: `T_CLR` cycles if `word` is 9'h001, 9'h002 or 9'h003 (clear/home); otherwise `T_CMD`.
  - On the last WAIT cycle: if `romaddr`==127, go to DONE with `romaddr` unchanged (no wrap).
  - Otherwise increment `romaddr` and go to FETCH.
- DONE: `BUSY`=0, `DONE`=1, `LCD_E`=0. RS/DB/`romaddr` hold their last values.
- START in DONE: `romaddr`=0, `DONE`=0, `BUSY`=1, next state FETCH. There is no power-on wait on restart.
- START in any other state is ignored.
- `LCD_RW` is tied to 0 at all times. The busy flag is never read; only timed delays are used.
- RESET at any time returns all registers to their reset values immediately (asynchronously). If E was high, it falls without a hold phase. The sequence restarts with the power-on wait.

## Timing
- Cycle 0 is the first rising edge after RESET deasserts. FETCH of address 0 occurs at cycle `T_PWRON`.
- Per written word: 1 + `T_AS` + `T_PW` + `T_H` + wait cycles.
- `romaddr` changes only on the WAIT→FETCH transition, on START, and on reset. The new address is valid during FETCH, so zero ROM latency is required.
- RS/DB are stable from the first SETUP cycle through the last HOLD cycle. They change only on the FETCH→SETUP transition.
- Terminator: DONE is entered the cycle after FETCH of the terminator word, and `romaddr` stays on the terminator's address.
- All outputs are registered; no combinational path from `romq` to the LCD pins.

## Test plan
Test parameters: `T_PWRON`=10, `T_AS`=2, `T_PW`=4, `T_H`=2, `T_CMD`=8, `T_CLR`=20. Normal write = 17 cycles; clear write = 29 cycles.

- Reset release -> all outputs at reset values through cycle 9; FETCH at cycle 10 with `romaddr`=0, `BUSY`=1.
- ROM model {038, 00F, 001, 150, 0FF} -> exactly 4 E pulses, each 4 cycles high, with RS=0,0,0,1 and DB=38,0F,01,50. The gap after the 01 pulse is 22 cycles (hold + 20-cycle wait). `DONE`=1 from cycle 91, `romaddr`=4, no fifth pulse.
- Bus checker throughout the previous scenario -> RS/DB never change from 2 cycles before each E rise to 2 cycles after each E fall.
- START pulse in DONE -> `romaddr`=0, `BUSY`=1 next cycle, first E rise 3 cycles after START, no 10-cycle power-on wait. A START pulse mid-sequence -> no change to `romaddr` or pulse count.
- RESET asserted mid-PULSE -> `LCD_E`=0 before the next clock edge and all outputs at reset values; after release, the full sequence repeats starting with the power-on wait.
- ROM returns 9'h120 at every address -> 128 writes, then `DONE`=1 with `romaddr`=127 (no wrap to 0).
